// File: rtl/gpio_pkg.sv
// Shared register map and byte-lane helpers for the AHB-Lite GPIO responder.
package gpio_pkg;

   typedef logic [3:0] gpio_ofs_t;

   localparam gpio_ofs_t GPIO_OFS_OUT      = 4'h0;
   localparam gpio_ofs_t GPIO_OFS_OUT_SET  = 4'h1;
   localparam gpio_ofs_t GPIO_OFS_OUT_CLR  = 4'h2;
   localparam gpio_ofs_t GPIO_OFS_IN       = 4'h3;
   localparam gpio_ofs_t GPIO_OFS_IRQ_EN   = 4'h4;
   localparam gpio_ofs_t GPIO_OFS_IRQ_PEND = 4'h5;
   localparam gpio_ofs_t GPIO_OFS_SOC      = 4'h6;
   localparam gpio_ofs_t GPIO_OFS_BLD      = 4'h7;
   localparam gpio_ofs_t GPIO_OFS_CLKF     = 4'h8;

   // Little-endian lane enables for a transfer of the given HSIZE at HADDR[1:0].
   function automatic logic [3:0] gpio_lane_mask(input logic [2:0] size, input logic [1:0] addr);
      case (size)
         3'd0:    return 4'b0001 << addr;
         3'd1:    return addr[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] gpio_bit_mask(input logic [3:0] lanes);
      return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit input conditioner: 2-flop synchronizer followed by a hold-time debouncer.
module gpio_debounce
   import gpio_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic cpu_clk,
   input  logic pwrup_rst_n,
   input  logic pin_async,
   output logic pin_db
);

   localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

   logic [1:0]  sync_q;
   logic [15:0] cnt_q;
   logic        db_q;

   always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
      if (!pwrup_rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], pin_async};
         if (sync_q[1] == db_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            db_q  <= sync_q[1];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   assign pin_db = db_q;

endmodule

// File: rtl/ahb_lite_gpio.sv
// Zero-wait-state AHB-Lite responder: LED outputs, debounced buttons with edge
// interrupts, and read-only board identification registers.
module ahb_lite_gpio
   import gpio_pkg::*;
#(
   parameter int unsigned OUT_W           = 6,
   parameter int unsigned IN_W            = 5,
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [31:0] SOC_ID          = 32'h0,
   parameter logic [31:0] BLD_ID          = 32'h0,
   parameter logic [31:0] CLK_FREQ        = 32'h0
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic [31:0]      HADDR,
   input  logic [1:0]       HTRANS,
   input  logic [2:0]       HSIZE,
   input  logic             HWRITE,
   input  logic [31:0]      HWDATA,
   input  logic             HSEL,
   input  logic             HREADY_IN,
   output logic [31:0]      HRDATA,
   output logic             HREADY,
   output logic             HRESP,
   input  logic [IN_W-1:0]  GPIO_IN,
   output logic [OUT_W-1:0] GPIO_OUT,
   output logic             GPIO_INT
);

   logic            dp_valid_q;
   logic            dp_write_q;
   gpio_ofs_t       dp_ofs_q;
   logic [3:0]      dp_lanes_q;

   logic [OUT_W-1:0] out_q, out_d;
   logic [IN_W-1:0]  irq_en_q, irq_en_d;
   logic [IN_W-1:0]  irq_pend_q, irq_pend_d, pend_clr;
   logic [IN_W-1:0]  in_db, in_db_prev_q;

   logic        wr_commit;
   logic [31:0] bmask, wd;
   logic [31:0] rd_word;
   logic        unused_ok;

   for (genvar i = 0; i < IN_W; i++) begin : g_db
      gpio_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .cpu_clk    (HCLK),
         .pwrup_rst_n(HRESETn),
         .pin_async  (GPIO_IN[i]),
         .pin_db     (in_db[i])
      );
   end

   // Address phase is only sampled when the bus is ready; a stalled data phase holds.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_ofs_q   <= GPIO_OFS_OUT;
         dp_lanes_q <= '0;
      end else if (HREADY_IN) begin
         dp_valid_q <= HSEL & HTRANS[1];
         if (HSEL & HTRANS[1]) begin
            dp_write_q <= HWRITE;
            dp_ofs_q   <= HADDR[5:2];
            dp_lanes_q <= gpio_lane_mask(HSIZE, HADDR[1:0]);
         end
      end
   end

   always_comb begin
      wr_commit = dp_valid_q & dp_write_q & HREADY_IN;
      bmask     = gpio_bit_mask(dp_lanes_q);
      wd        = HWDATA & bmask;
      out_d     = out_q;
      irq_en_d  = irq_en_q;
      pend_clr  = '0;
      if (wr_commit) begin
         case (dp_ofs_q)
            GPIO_OFS_OUT:      out_d = (out_q & ~bmask[OUT_W-1:0]) | wd[OUT_W-1:0];
            GPIO_OFS_OUT_SET:  out_d = out_q | wd[OUT_W-1:0];
            GPIO_OFS_OUT_CLR:  out_d = out_q & ~wd[OUT_W-1:0];
            GPIO_OFS_IRQ_EN:   irq_en_d = (irq_en_q & ~bmask[IN_W-1:0]) | wd[IN_W-1:0];
            GPIO_OFS_IRQ_PEND: pend_clr = wd[IN_W-1:0];
            default: ;
         endcase
      end
      // A rising edge landing on the same cycle as a W1C keeps the bit set.
      irq_pend_d = (irq_pend_q & ~pend_clr) | (in_db & ~in_db_prev_q);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         out_q        <= '0;
         irq_en_q     <= '0;
         irq_pend_q   <= '0;
         in_db_prev_q <= '0;
      end else begin
         out_q        <= out_d;
         irq_en_q     <= irq_en_d;
         irq_pend_q   <= irq_pend_d;
         in_db_prev_q <= in_db;
      end
   end

   always_comb begin
      rd_word = '0;
      case (dp_ofs_q)
         GPIO_OFS_OUT,
         GPIO_OFS_OUT_SET,
         GPIO_OFS_OUT_CLR:  rd_word = 32'(out_q);
         GPIO_OFS_IN:       rd_word = 32'(in_db);
         GPIO_OFS_IRQ_EN:   rd_word = 32'(irq_en_q);
         GPIO_OFS_IRQ_PEND: rd_word = 32'(irq_pend_q);
         GPIO_OFS_SOC:      rd_word = SOC_ID;
         GPIO_OFS_BLD:      rd_word = BLD_ID;
         GPIO_OFS_CLKF:     rd_word = CLK_FREQ;
         default:           rd_word = '0;
      endcase
   end

   assign HRDATA    = (dp_valid_q && !dp_write_q) ? rd_word : '0;
   assign HREADY    = 1'b1;
   assign HRESP     = 1'b0;
   assign GPIO_OUT  = out_q;
   assign GPIO_INT  = |(irq_pend_q & irq_en_q);
   assign unused_ok = ^{HADDR[31:6], HTRANS[0], wd};

endmodule

// File: tb/tb_ahb_lite_gpio.sv
// Directed bench for ahb_lite_gpio: vector table for register accesses, hand
// sequences for debounce, interrupt, stall and reset behaviour.
module tb_ahb_lite_gpio;

   localparam int unsigned OUT_W = 6;
   localparam int unsigned IN_W  = 5;
   localparam logic [31:0] SOC   = 32'hC0FF_EE01;
   localparam logic [31:0] BLD   = 32'h2024_0101;
   localparam logic [31:0] CLKF  = 32'd50_000_000;

   logic             HCLK = 1'b0;
   logic             HRESETn;
   logic [31:0]      HADDR;
   logic [1:0]       HTRANS;
   logic [2:0]       HSIZE;
   logic             HWRITE;
   logic [31:0]      HWDATA;
   logic             HSEL;
   logic             HREADY_IN;
   logic [31:0]      HRDATA;
   logic             HREADY;
   logic             HRESP;
   logic [IN_W-1:0]  GPIO_IN;
   logic [OUT_W-1:0] GPIO_OUT;
   logic             GPIO_INT;

   always #5 HCLK = ~HCLK;

   ahb_lite_gpio #(
      .OUT_W          (OUT_W),
      .IN_W           (IN_W),
      .DEBOUNCE_CYCLES(16'd4),
      .SOC_ID         (SOC),
      .BLD_ID         (BLD),
      .CLK_FREQ       (CLKF)
   ) dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .HADDR    (HADDR),
      .HTRANS   (HTRANS),
      .HSIZE    (HSIZE),
      .HWRITE   (HWRITE),
      .HWDATA   (HWDATA),
      .HSEL     (HSEL),
      .HREADY_IN(HREADY_IN),
      .HRDATA   (HRDATA),
      .HREADY   (HREADY),
      .HRESP    (HRESP),
      .GPIO_IN  (GPIO_IN),
      .GPIO_OUT (GPIO_OUT),
      .GPIO_INT (GPIO_INT)
   );

   typedef struct {
      logic        wr;
      logic [5:0]  addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [5:0]  exp_out;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic wr, input logic [5:0] a, input logic [2:0] sz,
                               input logic [31:0] wd, input logic [31:0] rd,
                               input logic [5:0] o);
      vec_t v;
      v.wr = wr; v.addr = a; v.size = sz; v.wdata = wd; v.exp_rd = rd; v.exp_out = o;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HADDR  = 32'h0;
      HSIZE  = 3'd2;
   endtask

   task automatic addr_ph(input logic wr, input logic [5:0] a, input logic [2:0] sz);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = wr;
      HADDR  = 32'hA000_0000 | 32'(a);
      HSIZE  = sz;
   endtask

   // Starts and ends 1 time unit after a rising edge.
   task automatic xfer(input logic wr, input logic [5:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd);
      addr_ph(wr, a, sz);
      cycle();
      idle();
      HWDATA = wd;
      @(negedge HCLK);
      rd = HRDATA;
      cycle();
   endtask

   task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      xfer(1'b0, a, 3'd2, 32'h0, rd);
      check(name, rd, exp);
   endtask

   task automatic wr_word(input logic [5:0] a, input logic [31:0] d);
      logic [31:0] rd;
      xfer(1'b1, a, 3'd2, d, rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;

      vecs.push_back(mk(1, 6'h00, 3'd2, 32'h0000_0015, 32'h0,      6'h15));
      vecs.push_back(mk(0, 6'h00, 3'd2, 32'h0,         32'h15,     6'h15));
      vecs.push_back(mk(1, 6'h04, 3'd2, 32'h0000_0002, 32'h0,      6'h17));
      vecs.push_back(mk(0, 6'h04, 3'd2, 32'h0,         32'h17,     6'h17));
      vecs.push_back(mk(1, 6'h08, 3'd2, 32'h0000_0001, 32'h0,      6'h16));
      vecs.push_back(mk(0, 6'h08, 3'd2, 32'h0,         32'h16,     6'h16));
      vecs.push_back(mk(1, 6'h01, 3'd0, 32'h0000_FF00, 32'h0,      6'h16));
      vecs.push_back(mk(1, 6'h02, 3'd1, 32'hFFFF_0000, 32'h0,      6'h16));
      vecs.push_back(mk(1, 6'h07, 3'd0, 32'hFF00_0000, 32'h0,      6'h16));
      vecs.push_back(mk(1, 6'h00, 3'd0, 32'h0000_002A, 32'h0,      6'h2A));
      vecs.push_back(mk(1, 6'h00, 3'd2, 32'hFFFF_FFC5, 32'h0,      6'h05));
      vecs.push_back(mk(0, 6'h00, 3'd2, 32'h0,         32'h05,     6'h05));
      vecs.push_back(mk(0, 6'h18, 3'd2, 32'h0,         SOC,        6'h05));
      vecs.push_back(mk(0, 6'h1C, 3'd2, 32'h0,         BLD,        6'h05));
      vecs.push_back(mk(0, 6'h20, 3'd2, 32'h0,         CLKF,       6'h05));
      vecs.push_back(mk(0, 6'h3C, 3'd2, 32'h0,         32'h0,      6'h05));
      vecs.push_back(mk(0, 6'h24, 3'd2, 32'h0,         32'h0,      6'h05));
      vecs.push_back(mk(1, 6'h18, 3'd2, 32'h1234_5678, 32'h0,      6'h05));
      vecs.push_back(mk(0, 6'h18, 3'd2, 32'h0,         SOC,        6'h05));
      vecs.push_back(mk(1, 6'h10, 3'd2, 32'hFFFF_FFFF, 32'h0,      6'h05));
      vecs.push_back(mk(0, 6'h10, 3'd2, 32'h0,         32'h1F,     6'h05));
      vecs.push_back(mk(1, 6'h10, 3'd2, 32'h0,         32'h0,      6'h05));
      vecs.push_back(mk(0, 6'h10, 3'd2, 32'h0,         32'h0,      6'h05));
      vecs.push_back(mk(0, 6'h0C, 3'd2, 32'h0,         32'h0,      6'h05));
      vecs.push_back(mk(0, 6'h14, 3'd2, 32'h0,         32'h0,      6'h05));
      vecs.push_back(mk(1, 6'h28, 3'd2, 32'hFFFF_FFFF, 32'h0,      6'h05));
      vecs.push_back(mk(0, 6'h00, 3'd2, 32'h0,         32'h05,     6'h05));

      // Reset state
      HRESETn   = 1'b0;
      HREADY_IN = 1'b1;
      HWDATA    = 32'h0;
      GPIO_IN   = '0;
      idle();
      repeat (3) @(posedge HCLK);
      #1;
      check("reset GPIO_OUT", 32'(GPIO_OUT), 32'h0);
      check("reset HRDATA", HRDATA, 32'h0);
      check("reset HREADY/HRESP", {30'h0, HREADY, HRESP}, 32'h2);
      check("reset GPIO_INT", 32'(GPIO_INT), 32'h0);
      HRESETn = 1'b1;
      cycle();

      // Register table
      foreach (vecs[i]) begin
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd);
         if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d GPIO_OUT", i), 32'(GPIO_OUT), 32'(vecs[i].exp_out));
         check($sformatf("vec%0d HREADY/HRESP", i), {30'h0, HREADY, HRESP}, 32'h2);
      end

      // Back-to-back write then read of OUT
      addr_ph(1'b1, 6'h00, 3'd2);
      cycle();
      HWDATA = 32'h15;
      addr_ph(1'b0, 6'h00, 3'd2);
      @(negedge HCLK);
      check("b2b out before commit", 32'(GPIO_OUT), 32'h05);
      cycle();
      idle();
      check("b2b GPIO_OUT", 32'(GPIO_OUT), 32'h15);
      @(negedge HCLK);
      check("b2b read", HRDATA, 32'h15);
      cycle();

      // Debounce: 3-cycle glitch rejected, long hold accepted
      GPIO_IN[0] = 1'b1;
      repeat (3) cycle();
      GPIO_IN[0] = 1'b0;
      repeat (10) cycle();
      rd_chk("glitch IN", 6'h0C, 32'h0);
      rd_chk("glitch PEND", 6'h14, 32'h0);
      GPIO_IN[0] = 1'b1;
      repeat (10) cycle();
      rd_chk("hold IN", 6'h0C, 32'h1);
      rd_chk("hold PEND", 6'h14, 32'h1);
      check("int masked", 32'(GPIO_INT), 32'h0);
      wr_word(6'h10, 32'h1);
      check("int enabled", 32'(GPIO_INT), 32'h1);

      // W1C drops the interrupt the cycle after the data phase
      addr_ph(1'b1, 6'h14, 3'd2);
      cycle();
      idle();
      HWDATA = 32'h1;
      @(negedge HCLK);
      check("w1c int during dp", 32'(GPIO_INT), 32'h1);
      cycle();
      check("w1c int after", 32'(GPIO_INT), 32'h0);
      rd_chk("w1c PEND", 6'h14, 32'h0);

      // Set beats clear: W1C commits on the same edge a new rise sets PEND
      GPIO_IN[0] = 1'b0;
      repeat (10) cycle();
      rd_chk("fall IN", 6'h0C, 32'h0);
      rd_chk("fall PEND", 6'h14, 32'h0);
      GPIO_IN[0] = 1'b1;
      repeat (5) cycle();
      addr_ph(1'b1, 6'h14, 3'd2);
      cycle();
      idle();
      HWDATA = 32'h1;
      cycle();
      check("set-wins GPIO_INT", 32'(GPIO_INT), 32'h1);
      rd_chk("set-wins PEND", 6'h14, 32'h1);

      // Stalled bus: address ignored, then a held data phase
      HREADY_IN = 1'b0;
      addr_ph(1'b1, 6'h00, 3'd2);
      cycle();
      idle();
      HREADY_IN = 1'b1;
      HWDATA = 32'h3F;
      cycle();
      cycle();
      check("stall addr ignored", 32'(GPIO_OUT), 32'h15);
      addr_ph(1'b1, 6'h00, 3'd2);
      cycle();
      idle();
      HWDATA    = 32'h0A;
      HREADY_IN = 1'b0;
      cycle();
      check("stall dp hold 1", 32'(GPIO_OUT), 32'h15);
      cycle();
      check("stall dp hold 2", 32'(GPIO_OUT), 32'h15);
      HREADY_IN = 1'b1;
      cycle();
      check("stall dp commit", 32'(GPIO_OUT), 32'h0A);

      // Reset in the middle of a write/read burst
      addr_ph(1'b1, 6'h00, 3'd2);
      cycle();
      HWDATA = 32'h3F;
      addr_ph(1'b0, 6'h00, 3'd2);
      #2;
      HRESETn = 1'b0;
      #1;
      check("midrst GPIO_OUT", 32'(GPIO_OUT), 32'h0);
      check("midrst HRDATA", HRDATA, 32'h0);
      check("midrst GPIO_INT", 32'(GPIO_INT), 32'h0);
      check("midrst HREADY/HRESP", {30'h0, HREADY, HRESP}, 32'h2);
      cycle();
      idle();
      HRESETn = 1'b1;
      cycle();
      check("post-rst GPIO_OUT", 32'(GPIO_OUT), 32'h0);
      rd_chk("post-rst IRQ_EN", 6'h10, 32'h0);
      rd_chk("post-rst OUT", 6'h00, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ahb_lite_gpio.md
# ahb_lite_gpio

AHB-Lite responder on the SCR1 data bus that drives the board LEDs, samples the board buttons and exposes read-only board ID registers. The block sits beside the UART and ROM responders behind the slave mux. It decodes its own word offsets, has zero wait states, and raises a level interrupt on debounced button rising edges.

## Interface
- `OUT_W`, default 6: number of LED outputs.
- `IN_W`, default 5: number of button inputs.
- `DEBOUNCE_CYCLES`, default 16'd50000: number of cycles a synchronized input must hold a new value before the debounced value changes. Must be ≥ 2.
- `SOC_ID`, default 32'h0: value returned by the SOC_ID register.
- `BLD_ID`, default 32'h0: value returned by the BLD_ID register.
- `CLK_FREQ`, default 32'h0: value returned by the CLK_FREQ register.
- `HCLK  in  1`: the only clock.
- `HRESETn  in  1`: asynchronous, active-low reset.
- `HADDR  in  32`: address; only `[5:0]` is decoded.
- `HTRANS  in  2`: transfer type; `HTRANS[1]` = NONSEQ/SEQ.
- `HSIZE  in  3`: 0 = byte, 1 = half, 2 = word.
- `HWRITE  in  1`: write transfer.
- `HWDATA  in  32`: write data, valid in the data phase.
- `HSEL  in  1`: slave select from the decoder.
- `HREADY_IN  in  1`: bus HREADY.
- `HRDATA  out  32`: read data.
- `HREADY  out  1`: HREADYOUT; constant 1.
- `HRESP  out  1`: constant 0 (OKAY).
- `GPIO_IN  in  IN_W`: asynchronous button inputs.
- `GPIO_OUT  out  OUT_W`: LED drive, registered.
- `GPIO_INT  out  1`: interrupt, equal to `|(IRQ_PEND & IRQ_EN)`.

## Operation
- **Address phase.** Accepted when `HSEL & HTRANS[1] & HREADY_IN`. On acceptance, latch offset `HADDR[5:2]`, `HWRITE`, and the byte-lane mask built from `HSIZE` and `HADDR[1:0]` (little-endian). Otherwise clear the data-phase valid flag.
- **Register map.** Offsets are bytes. Only implemented low bits are stored.
  - 0x00 OUT, RW.
  - 0x04 OUT_SET: write 1 to set bits; reads return OUT.
  - 0x08 OUT_CLR: write 1 to clear bits; reads return OUT.
  - 0x0C IN, RO: debounced inputs.
  - 0x10 IRQ_EN, RW.
  - 0x14 IRQ_PEND: reads return pending bits; write 1 to clear.
  - 0x18 SOC_ID, RO.
  - 0x1C BLD_ID, RO.
  - 0x20 CLK_FREQ, RO.
  - 0x24–0x3C: read 0; writes ignored. HRESP stays OKAY.
- **Writes.** Committed at the end of the data phase (`HREADY_IN` high), masked by the byte lanes. Writes to RO registers are ignored.
- **Reads.** `HRDATA` is a combinational mux of the latched offset over current register state while a read data phase is valid. It is 0 otherwise.
- **Debounce.** Each input passes through a 2-flop synchronizer. A per-bit counter resets whenever the synchronized value equals the debounced value. When the counter reaches `DEBOUNCE_CYCLES-1` with the value still different, the debounced bit takes the new value and the counter clears.
- **Edge detect.** A debounced 0→1 transition sets the corresponding `IRQ_PEND` bit. If set and clear hit the same bit in the same cycle, set wins.
- **Reset values.** OUT, IRQ_EN, IRQ_PEND, debounced values, synchronizers and counters are 0. HRDATA = 0, HREADY = 1, HRESP = 0, GPIO_INT = 0. Inputs idle high become debounced 1 after reset and set IRQ_PEND. Software clears IRQ_PEND before setting IRQ_EN.

## Timing
- Zero wait states: each data phase completes in one cycle, and back-to-back transfers are supported.
- Write to OUT/OUT_SET/OUT_CLR in the data phase of cycle N: `GPIO_OUT` changes at edge N+1.
- Write in cycle N followed by a read of the same register whose data phase is in cycle N+1: the read returns the new value.
- Input step to debounced IN: 2 (sync) + `DEBOUNCE_CYCLES` cycles.
- Debounced rising edge to `IRQ_PEND` set: +1 cycle. GPIO_INT follows in the same cycle.
- A W1C write to IRQ_PEND drops `GPIO_INT` the cycle after the data phase.
- Bus stall (`HREADY_IN` low from another slave): no address phase accepted. A pending data phase holds until `HREADY_IN` is high.
- Reset asserted mid-transfer: all state returns to reset values immediately; no partial write is committed.

## Structure
- Package `gpio_pkg`: register offset localparams (`GPIO_OFS_OUT` … `GPIO_OFS_CLKF`), a 4-bit offset typedef, and the byte-lane mask function.
- Sub-module `gpio_debounce`: one instance per input bit, containing the synchronizer, counter and debounced flop. Parameter `DEBOUNCE_CYCLES`.

## Test plan
- Write word 0x15 to 0x00, then read 0x00 back-to-back → `GPIO_OUT` = 6'b010101 one cycle after the data phase; read returns 0x15.
- Write 0x02 to 0x04, then 0x01 to 0x08 → `GPIO_OUT` 0x15 → 0x17 → 0x16.
- Byte write 0xFF to offset 0x01 of OUT → OUT unchanged, because the implemented bits sit in byte 0.
- With `DEBOUNCE_CYCLES`=4: hold `GPIO_IN[0]`=1 for 3 cycles then drop it → IN stays 0. Hold it 6+ cycles → IN[0]=1; IRQ_PEND[0]=1; with IRQ_EN[0]=1, `GPIO_INT`=1.
- Write 0x1 to 0x14 in the same cycle a new rising edge on bit 0 arrives → IRQ_PEND[0] remains 1.
- Read 0x18/0x1C/0x20/0x3C → SOC_ID, BLD_ID, CLK_FREQ, 0. HRESP=0 and HREADY=1 throughout; assert `HRESETn` mid-burst → all outputs return to reset values.
